// File: rtl/std_pipe_share_arb.sv
// Round-robin arbiter that time-shares one multi-cycle go/done arithmetic unit
// among PORTS requesters, latching the winner's operands for the whole operation.
module std_pipe_share_arb #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PORTS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PORTS-1:0]       req_go,
  input  logic [PORTS*WIDTH-1:0] req_left,
  input  logic [PORTS*WIDTH-1:0] req_right,
  output logic [WIDTH-1:0]       req_out,
  output logic [PORTS-1:0]       req_done,
  output logic                   unit_go,
  output logic [WIDTH-1:0]       unit_left,
  output logic [WIDTH-1:0]       unit_right,
  input  logic [WIDTH-1:0]       unit_out,
  input  logic                   unit_done
);

  localparam int unsigned PW = $clog2(PORTS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    grant_q, grant_d;
  logic             go_q, go_d;
  logic [WIDTH-1:0] left_q, left_d;
  logic [WIDTH-1:0] right_q, right_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [PORTS-1:0] done_q, done_d;

  logic [PW-1:0]    pick;
  logic [PW-1:0]    cand;
  logic             pick_vld;

  // First requester at or above ptr, wrapping past PORTS-1 back to 0.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      cand = PW'((32'(ptr_q) + k) % PORTS);
      if (!pick_vld && req_go[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    go_d    = 1'b0;
    left_d  = left_q;
    right_d = right_q;
    out_d   = out_q;
    done_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = BUSY;
          grant_d = pick;
          go_d    = 1'b1;
          left_d  = req_left[32'(pick)*WIDTH +: WIDTH];
          right_d = req_right[32'(pick)*WIDTH +: WIDTH];
        end
      end
      BUSY: begin
        if (unit_done) begin
          state_d         = DONE;
          out_d           = unit_out;
          done_d[grant_q] = 1'b1;
          ptr_d           = (grant_q == PW'(PORTS-1)) ? '0 : grant_q + 1'b1;
        end else begin
          go_d = 1'b1;
        end
      end
      // Dead cycle with go low lets the unit flush before the next grant.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      go_q    <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      out_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      go_q    <= go_d;
      left_q  <= left_d;
      right_q <= right_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign unit_go    = go_q;
  assign unit_left  = left_q;
  assign unit_right = right_q;
  assign req_out    = out_q;
  assign req_done   = done_q;

endmodule
